// File: rtl/rv32imf_obi_mem_responder.sv
// OBI-style memory responder: grants req/gnt handshakes, does word reads and byte-enabled
// writes on an internal array, and answers in order after a fixed response latency.
module rv32imf_obi_mem_responder #(
  parameter int ADDR_WIDTH      = 10,
  parameter int RESP_LAT        = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int             DEPTH   = 2 ** ADDR_WIDTH;
  localparam int             CNT_W   = 4;
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

  if (RESP_LAT < 1 || RESP_LAT > 8) begin : g_bad_lat
    $error("RESP_LAT must be in 1..8");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_max
    $error("MAX_OUTSTANDING must be at least 1");
  end

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  accept;
  logic [CNT_W-1:0]      outstanding;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  unused_addr;

  logic [RESP_LAT-1:0]   vld_p;
  logic [RESP_LAT-1:0]   err_p;
  logic [31:0]           rdata_p [RESP_LAT];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

  assign word_idx    = addr_i[ADDR_WIDTH+1:2];
  assign in_range    = (addr_i[31:ADDR_WIDTH+2] == '0);
  assign unused_addr = ^addr_i[1:0];

  // The last stage is the one presenting rvalid_o; it counts as answered, so only the
  // earlier stages hold transactions still waiting for their response.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RESP_LAT - 1; i++) begin
      outstanding = outstanding + CNT_W'(vld_p[i]);
    end
  end

  assign gnt_o  = req_i & ~stall_i & ~rst_i & (outstanding < MAX_OUT);
  assign accept = req_i & gnt_o;

  assign resp_rdata = (accept && !we_i && in_range) ? mem[word_idx] : '0;
  assign resp_err   = accept && !in_range;

  // Array write at the acceptance edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      mem[word_idx] <= merge_bytes(mem[word_idx], wdata_i, be_i);
    end
  end

  // Response pipeline stage 0 loads the accepted response, later stages shift.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p <= '0;
      err_p <= '0;
      for (int i = 0; i < RESP_LAT; i++) rdata_p[i] <= '0;
    end else begin
      vld_p[0]   <= accept;
      err_p[0]   <= resp_err;
      rdata_p[0] <= resp_rdata;
      for (int i = 1; i < RESP_LAT; i++) begin
        vld_p[i]   <= vld_p[i-1];
        err_p[i]   <= err_p[i-1];
        rdata_p[i] <= rdata_p[i-1];
      end
    end
  end

  assign rvalid_o = vld_p[RESP_LAT-1];
  assign rdata_o  = rdata_p[RESP_LAT-1];
  assign err_o    = err_p[RESP_LAT-1];

endmodule
